// File: rtl/enemy_draw_control.sv
// enemy_draw_control
// Sequences the 4x4 enemy sprite datapath once per animation tick: erase the
// sprite at its current x, step x between X_MIN and X_MAX (bouncing at the
// bounds), then redraw it. Tracks health from player hits and parks in a dead
// state after the erase pass once health reaches zero.
// Optional feature macro: ENEMY_HIT_FLASH_EN -- when defined, the first draw
// after a hit uses red (3'b100) instead of enemy_colour_i.
module enemy_draw_control #(
    parameter logic [6:0] X_MIN       = 7'd8,
    parameter logic [6:0] X_MAX       = 7'd100,
    parameter logic [6:0] STEP        = 7'd4,
    parameter logic [6:0] Y_POS       = 7'd40,
    parameter logic [2:0] HEALTH_INIT = 3'd5
) (
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       go_i,
    input  logic       hit_i,
    input  logic [2:0] enemy_colour_i,
    output logic [6:0] point_o,
    output logic [2:0] c_in_o,
    output logic       load_x_o,
    output logic       load_y_o,
    output logic       load_colour_o,
    output logic       enable_o,
    output logic       plot_o,
    output logic       busy_o,
    output logic [2:0] health_o,
    output logic       defeated_o
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_E_LX  = 4'd1,
        S_E_LY  = 4'd2,
        S_ERASE = 4'd3,
        S_MOVE  = 4'd4,
        S_D_LX  = 4'd5,
        S_D_LY  = 4'd6,
        S_DRAW  = 4'd7,
        S_DEAD  = 4'd8
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] cur_x_q, cur_x_d;
    logic       dir_left_q, dir_left_d;
    logic [2:0] health_q, health_d;
    logic [2:0] draw_colour;
    logic       defeated;

    // Move arithmetic is done one bit wider so the right-bound test cannot wrap.
    logic [7:0] sum_x;
    logic [7:0] left_lim;
    logic [6:0] diff_x;

    assign sum_x    = {1'b0, cur_x_q} + {1'b0, STEP};
    assign left_lim = {1'b0, X_MIN} + {1'b0, STEP};
    assign diff_x   = cur_x_q - STEP;
    assign defeated = (health_q == 3'd0);

`ifdef ENEMY_HIT_FLASH_EN
    logic flash_q, flash_d;

    // Flash flag: set by any live hit, consumed by the next draw colour load.
    always_comb begin
        flash_d = flash_q;
        if (hit_i && (state_q != S_DEAD)) begin
            flash_d = 1'b1;
        end else if (state_q == S_D_LX) begin
            flash_d = 1'b0;
        end
    end

    // Flash flag register.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            flash_q <= 1'b0;
        end else begin
            flash_q <= flash_d;
        end
    end

    assign draw_colour = flash_q ? 3'b100 : enemy_colour_i;
`else
    assign draw_colour = enemy_colour_i;
`endif

    // FSM state register.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the DEAD decision uses health as of the last erase cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_i) state_d = S_E_LX;
            S_E_LX:  state_d = S_E_LY;
            S_E_LY:  state_d = S_ERASE;
            S_ERASE: if (cnt_q == 4'd15) state_d = defeated ? S_DEAD : S_MOVE;
            S_MOVE:  state_d = S_D_LX;
            S_D_LX:  state_d = S_D_LY;
            S_D_LY:  state_d = S_DRAW;
            S_DRAW:  if (cnt_q == 4'd15) state_d = S_IDLE;
            S_DEAD:  state_d = S_DEAD;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: strobes and load values for the datapath and VGA adapter.
    always_comb begin
        point_o       = 7'd0;
        c_in_o        = 3'd0;
        load_x_o      = 1'b0;
        load_y_o      = 1'b0;
        load_colour_o = 1'b0;
        enable_o      = 1'b0;
        plot_o        = 1'b0;
        busy_o        = 1'b1;
        case (state_q)
            S_IDLE, S_DEAD: busy_o = 1'b0;
            S_E_LX: begin
                point_o       = cur_x_q;
                load_x_o      = 1'b1;
                load_colour_o = 1'b1;
            end
            S_D_LX: begin
                point_o       = cur_x_q;
                c_in_o        = draw_colour;
                load_x_o      = 1'b1;
                load_colour_o = 1'b1;
            end
            S_E_LY, S_D_LY: begin
                point_o  = Y_POS;
                load_y_o = 1'b1;
            end
            S_ERASE, S_DRAW: begin
                enable_o = 1'b1;
                plot_o   = 1'b1;
            end
            default: ;
        endcase
    end

    // Next values for the burst counter, sprite position and health.
    always_comb begin
        cnt_d      = 4'd0;
        cur_x_d    = cur_x_q;
        dir_left_d = dir_left_q;
        health_d   = health_q;

        // Counter runs only inside bursts and wraps to 0 after 16 cycles,
        // matching the datapath pixel counter.
        if ((state_q == S_ERASE) || (state_q == S_DRAW)) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (state_q == S_MOVE) begin
            if (!dir_left_q) begin
                if (sum_x > {1'b0, X_MAX}) begin
                    cur_x_d    = diff_x;
                    dir_left_d = 1'b1;
                end else begin
                    cur_x_d = sum_x[6:0];
                end
            end else begin
                if ({1'b0, cur_x_q} < left_lim) begin
                    cur_x_d    = sum_x[6:0];
                    dir_left_d = 1'b0;
                end else begin
                    cur_x_d = diff_x;
                end
            end
        end

        if (hit_i && (state_q != S_DEAD) && (health_q != 3'd0)) begin
            health_d = health_q - 3'd1;
        end
    end

    // Datapath-side registers: burst counter, position, direction, health.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q      <= 4'd0;
            cur_x_q    <= X_MIN;
            dir_left_q <= 1'b0;
            health_q   <= HEALTH_INIT;
        end else begin
            cnt_q      <= cnt_d;
            cur_x_q    <= cur_x_d;
            dir_left_q <= dir_left_d;
            health_q   <= health_d;
        end
    end

    assign health_o   = health_q;
    assign defeated_o = defeated;

endmodule

// File: tb/tb_enemy_draw_control.sv
// Scoreboard bench for enemy_draw_control: each tick pushes the expected
// colour/x loads, plot bursts and busy edges; a negedge monitor pops and
// compares them as the DUT presents them.
module tb_enemy_draw_control;

`ifdef ENEMY_HIT_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       go;
    logic       hit;
    logic [2:0] colour;
    logic [6:0] point;
    logic [2:0] c_in;
    logic       load_x, load_y, load_colour, enable, plot, busy, defeated;
    logic [2:0] health;

    enemy_draw_control dut (
        .clock_i        (clk),
        .resetn_i       (resetn),
        .go_i           (go),
        .hit_i          (hit),
        .enemy_colour_i (colour),
        .point_o        (point),
        .c_in_o         (c_in),
        .load_x_o       (load_x),
        .load_y_o       (load_y),
        .load_colour_o  (load_colour),
        .enable_o       (enable),
        .plot_o         (plot),
        .busy_o         (busy),
        .health_o       (health),
        .defeated_o     (defeated)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int c;
        int pt;
        int col;
    } lx_t;

    typedef struct {
        int start;
        int len;
    } burst_t;

    lx_t    lx_q[$];
    burst_t bq[$];
    int     busy_q[$];

    // ---------------- monitor ----------------
    lx_t    e_lx;
    burst_t e_b;
    bit     in_run = 0;
    int     run_start = 0;
    int     run_len = 0;
    logic   busy_prev = 1'b0;
    int     e_busy;

    always @(negedge clk) begin
        if (load_x) begin
            if (lx_q.size() == 0) begin
                chk("unexpected_load_x", cyc, -1);
            end else begin
                e_lx = lx_q.pop_front();
                $display("load_x   cyc=%0d point=%0d c_in=%0d", cyc, point, c_in);
                chk("lx_cycle", cyc, e_lx.c);
                chk("lx_point", int'(point), e_lx.pt);
                chk("lx_colour", int'(c_in), e_lx.col);
                chk("lx_load_colour", int'(load_colour), 1);
            end
        end
        if (load_y) chk("ly_point", int'(point), 40);
        if (plot) begin
            chk("plot_enable", int'(enable), 1);
            if (!in_run) begin
                in_run    = 1;
                run_start = cyc;
                run_len   = 1;
            end else begin
                run_len++;
            end
        end else if (in_run) begin
            in_run = 0;
            $display("burst    start=%0d len=%0d", run_start, run_len);
            if (bq.size() == 0) begin
                chk("unexpected_burst", run_len, 0);
            end else begin
                e_b = bq.pop_front();
                chk("burst_start", run_start, e_b.start);
                chk("burst_len", run_len, e_b.len);
            end
        end
        if (busy !== busy_prev) begin
            $display("busy     cyc=%0d -> %0d", cyc, busy);
            if (busy_q.size() == 0) begin
                chk("unexpected_busy_edge", cyc, -1);
            end else begin
                e_busy = busy_q.pop_front();
                chk("busy_edge_cycle", cyc, e_busy);
            end
        end
        busy_prev = busy;
    end

    // ---------------- stimulus ----------------
    int mx = 8;
    bit mleft = 0;

    task automatic model_move();
        if (!mleft) begin
            if (mx + 4 > 100) begin
                mx    = mx - 4;
                mleft = 1;
            end else begin
                mx = mx + 4;
            end
        end else begin
            if (mx < 8 + 4) begin
                mx    = mx + 4;
                mleft = 0;
            end else begin
                mx = mx - 4;
            end
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((lx_q.size() != 0 || bq.size() != 0 || busy_q.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("seq_timeout", int'(k >= 200), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_tick(input logic [2:0] col, input bit exp_red,
                           input bit exp_dead, input bit with_hit, input bit extra_go);
        int  g0;
        lx_t l;
        burst_t b;
        @(posedge clk); #1;
        colour = col;
        go     = 1'b1;
        hit    = with_hit;
        g0     = cyc;
        l = '{c: g0 + 1, pt: mx, col: 0};
        lx_q.push_back(l);
        b = '{start: g0 + 3, len: 16};
        bq.push_back(b);
        busy_q.push_back(g0 + 1);
        if (exp_dead) begin
            busy_q.push_back(g0 + 19);
        end else begin
            model_move();
            l = '{c: g0 + 20, pt: mx, col: exp_red ? 4 : int'(col)};
            lx_q.push_back(l);
            b = '{start: g0 + 22, len: 16};
            bq.push_back(b);
            busy_q.push_back(g0 + 38);
        end
        @(posedge clk); #1;
        go  = 1'b0;
        hit = 1'b0;
        if (extra_go) begin
            repeat (4) @(posedge clk);
            #1 go = 1'b1;
            @(posedge clk);
            #1 go = 1'b0;
            repeat (31) @(posedge clk);
            #1 go = 1'b1;
            @(posedge clk);
            #1 go = 1'b0;
        end
        wait_drain();
    endtask

    task automatic hit_pulse(input int exp_health);
        @(posedge clk); #1 hit = 1'b1;
        @(posedge clk); #1 hit = 1'b0;
        $display("hit      cyc=%0d health=%0d defeated=%0d", cyc, health, defeated);
        chk("health", int'(health), exp_health);
        chk("defeated", int'(defeated), int'(exp_health == 0));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_plot"}, int'(plot), 0);
        chk({tag, "_enable"}, int'(enable), 0);
        chk({tag, "_load_x"}, int'(load_x), 0);
        chk({tag, "_point"}, int'(point), 0);
        chk({tag, "_c_in"}, int'(c_in), 0);
    endtask

    task automatic dead_no_effect();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        @(posedge clk); #1 hit = 1'b1;
        @(posedge clk); #1 hit = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        check_idle_outputs("dead");
        chk("dead_health", int'(health), 0);
        chk("dead_defeated", int'(defeated), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        go     = 1'b0;
        hit    = 1'b0;
        colour = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_health", int'(health), 5);
        chk("reset_defeated", int'(defeated), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Single tick: erase at 8 with black, draw at 12 with 3'b010.
        do_tick(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounce: ticks 2..24; tick 23 lands on 100, tick 24 turns back to 96.
        for (int i = 2; i <= 24; i++) begin
            do_tick(3'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Extra go pulses during busy are ignored.
        do_tick(3'b111, 1'b0, 1'b0, 1'b0, 1'b1);

        // One hit, then two ticks: first draw flashes red when the feature is built in.
        hit_pulse(4);
        do_tick(3'b011, FLASH, 1'b0, 1'b0, 1'b0);
        do_tick(3'b011, 1'b0, 1'b0, 1'b0, 1'b0);

        // Down to health 1, then go and hit together: erase only, then dead.
        hit_pulse(3);
        hit_pulse(2);
        hit_pulse(1);
        do_tick(3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("gohit_health", int'(health), 0);
        chk("gohit_defeated", int'(defeated), 1);
        dead_no_effect();

        // Asynchronous reset away from a clock edge.
        @(posedge clk); #1 resetn = 1'b0;
        #2;
        chk("async_reset_health", int'(health), 5);
        chk("async_reset_defeated", int'(defeated), 0);
        @(posedge clk); #1 resetn = 1'b1;
        mx    = 8;
        mleft = 0;

        // Five hits, then a tick that erases only and parks in dead.
        hit_pulse(4);
        hit_pulse(3);
        hit_pulse(2);
        hit_pulse(1);
        hit_pulse(0);
        hit_pulse(0);
        do_tick(3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        dead_no_effect();

        chk("lx_queue_empty", lx_q.size(), 0);
        chk("burst_queue_empty", bq.size(), 0);
        chk("busy_queue_empty", busy_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/enemy_draw_control.md
# enemy_draw_control

Controller that sequences the 4x4 enemy sprite datapath (the x/y/colour load registers plus the 16-pixel offset counter) once per animation tick. On each accepted tick it erases the sprite at its current position, steps it horizontally between two bounds, and redraws it, driving the datapath's load strobes, counter enable and the VGA plot strobe. It also tracks enemy health from player hits and stops drawing once the enemy is defeated. It sits between the rate-divider tick and the datapath/VGA adapter.

## Interface
- X_MIN, 7'd8: leftmost sprite x origin.
- X_MAX, 7'd100: rightmost sprite x origin.
- STEP, 7'd4: horizontal move per tick.
- Y_POS, 7'd40: fixed sprite y origin.
- HEALTH_INIT, 3'd5: health after reset.
- Legal configuration: X_MIN >= STEP, X_MAX - X_MIN >= STEP, X_MAX + STEP <= 127.

- clock  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- go  in  1  animation tick; single-cycle pulse.
- hit  in  1  player landed a punch; single-cycle pulse.
- enemy_colour  in  3  normal sprite colour.
- point  out  7  value presented to datapath x/y load.
- c_in  out  3  value presented to datapath colour load.
- load_x, load_y, load_colour  out  1 each  datapath load strobes.
- enable  out  1  datapath pixel-counter enable.
- plot  out  1  VGA write enable.
- busy  out  1  high while an erase/draw sequence runs.
- health  out  3  remaining health.
- defeated  out  1  health has reached 0.

## Operation
- States: IDLE, E_LX, E_LY, ERASE, MOVE, D_LX, D_LY, DRAW, DEAD.
- IDLE: go=1 -> E_LX; otherwise stay. go is ignored, not queued, outside IDLE.
- E_LX: point=cur_x, c_in=3'b000, load_x=1, load_colour=1 -> E_LY.
- E_LY: point=Y_POS, load_y=1 -> ERASE.
- ERASE: enable=1, plot=1 for exactly 16 cycles, counted by an internal 4-bit counter (0..15). Last cycle -> DEAD if defeated, else MOVE.
- MOVE: update cur_x and dir, then -> D_LX.
- D_LX: point=cur_x (updated), c_in=draw colour, load_x=1, load_colour=1 -> D_LY.
- D_LY: point=Y_POS, load_y=1 -> DRAW.
- DRAW: enable=1, plot=1 for 16 cycles -> IDLE.
- DEAD: all strobes low. Stays here until reset.
- Bursts are always exactly 16 enable cycles, so the datapath counter wraps back to 0 and stays aligned with the internal counter.
- Move arithmetic is 8-bit unsigned.
  - dir=right: if cur_x+STEP > X_MAX, set cur_x = cur_x-STEP and dir=left; else cur_x = cur_x+STEP.
  - dir=left: if cur_x < X_MIN+STEP, set cur_x = cur_x+STEP and dir=right; else cur_x = cur_x-STEP.
- Health:
  - hit=1 in any state except DEAD decrements health, saturating at 0.
  - defeated = (health == 0).
  - If hit occurs in the same cycle as go, both take effect.
  - A hit arriving before ERASE ends selects the DEAD path; a hit arriving later takes effect on the next tick.
- Outputs not named in a state are 0. point and c_in are 0 when not loading.

## Timing
- Reset (asynchronous) values: state=IDLE, cur_x=X_MIN, dir=right, health=HEALTH_INIT, internal counter=0. All strobes, busy and defeated are 0; point=0, c_in=0.
- go sampled in IDLE at cycle 0. Then:
  - E_LX at cycle 1, E_LY at 2.
  - ERASE at 3–18.
  - MOVE at 19.
  - D_LX at 20, D_LY at 21.
  - DRAW at 22–37.
  - IDLE at 38.
- busy=1 from cycle 1 through 37. busy=0 in IDLE and DEAD.
- health and defeated update one cycle after the hit pulse.
- Reset mid-sequence aborts immediately. The datapath must share resetn so its counter also returns to 0.

## Configuration
- ENEMY_HIT_FLASH_EN defined: a hit since the previous draw sets a flag. The next DRAW then uses c_in=3'b100 (red) and clears the flag.
- ENEMY_HIT_FLASH_EN undefined: DRAW always uses enemy_colour and no flag exists.

## Test plan
- Reset then single go with enemy_colour=3'b010:
  - E_LX drives point=8 and c_in=0.
  - 16 plot cycles at cycles 3–18.
  - D_LX drives point=12 and c_in=3'b010.
  - 16 plot cycles at cycles 22–37.
  - busy falls at cycle 38.
- Bounce: 24 ticks with defaults. cur_x reaches 100 on tick 23; tick 24 yields 96 with dir=left.
- go pulses during busy are ignored: exactly 32 plot cycles per accepted tick.
- Five hit pulses then go: health counts 5→0, defeated=1. The tick erases only (16 plots), then enters DEAD. Further go and hit have no effect.
- hit and go in the same cycle at health=1: erase, then DEAD, with no draw pass.
- With ENEMY_HIT_FLASH_EN: one hit then go gives draw c_in=3'b100; the next go gives enemy_colour.
